avalon_lsu_port: RTL and testbench
==================================

Name: avalon_lsu_port

Overview:
- Parametrised Avalon-MM master port between the MIPS core and the memory bus.
- Serves one outstanding fetch/load/store at a time from a valid/ready request channel.
- Generates address, read, write, byteenable and lane-replicated writedata; honours waitrequest.
- Returns aligned, sign/zero-extended read data, and flags misaligned, illegal and timed-out accesses instead of hanging.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and address.
- TIMEOUT, 255, max consecutive waitrequest-high cycles before abort; 0 disables timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request present.
- req_ready  out  1  port can accept a request.
- req_write  in  1  1=store, 0=load/fetch.
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  valid with rsp_valid; misaligned, illegal size or timeout.
- busy  out  1  state != IDLE.
- address  out  ADDR_WIDTH  word-aligned bus address, [1:0]=0.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- waitrequest  in  1  slave stall.
- writedata  out  32  lane-positioned store data.
- byteenable  out  4  active lanes.
- readdata  in  32  slave data, valid in the cycle read is high and waitrequest is low.

Behaviour:
- Reset (reset=0, async): state=IDLE; address, read, write, writedata, byteenable, rsp_valid, rsp_rdata, rsp_error, busy all 0. Any in-flight transaction is abandoned; no response is issued.
- States are IDLE, BUS and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge, latch the request.
  - If misaligned (half with addr[0]=1, word with addr[1:0]!=0) or req_size=3: go to RESP with error=1 and no bus activity.
  - Otherwise go to BUS and drive the bus outputs from the next cycle.
- BUS:
  - read=!write_latched, write=write_latched.
  - address={addr[AW-1:2],2'b00}.
  - Outputs are held stable while waitrequest=1.
  - Completion is any edge with waitrequest=0. On a read, readdata is captured at that edge. Then go to RESP.
  - Wait counter: cleared on entry, incremented each edge with waitrequest=1. If TIMEOUT!=0 and the count reaches TIMEOUT, go to RESP with error=1 and drop read/write.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 throughout BUS and RESP.
- Latency: zero-wait access gives request edge, one BUS cycle, then rsp_valid; total 2 cycles from acceptance. Each waitrequest cycle adds 1. Error path (misaligned/illegal): rsp_valid 1 cycle after acceptance.
- byteenable:
  - byte: 1<<addr[1:0].
  - half: addr[1]?4'b1100:4'b0011.
  - word: 4'b1111.
  - 0 outside BUS.
- writedata:
  - byte: replicated to all 4 lanes.
  - half: replicated to both halves.
  - word: as is.
  - 0 outside BUS.
- Load extraction:
  - Select lane by addr[1:0]: byte lane = readdata[8*k+7:8*k]; half = readdata[16*addr[1]+15 : 16*addr[1]].
  - Extend to 32 bits: sign-extend if req_signed, else zero-extend. Word ignores req_signed.
- Stores: rsp_rdata=0. Errors: rsp_rdata=0.
- A req_valid asserted while not ready is ignored; the core must hold it until accepted.
- read and write are never both 1.

Test Plan:
- Word load, addr 0x100, waitrequest=0, readdata=0xDEADBEEF -> read=1, address=0x100, byteenable=1111 one cycle; rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_error=0.
- Signed byte load, addr 0x203, readdata=0x80FF_1234 -> byteenable=1000, rsp_rdata=0xFFFFFF80. Same access with req_signed=0 -> 0x00000080.
- Half store, addr 0x12, wdata=0x0000ABCD, waitrequest high 3 cycles -> write, address=0x10, byteenable=1100, writedata=0xABCDABCD held stable 4 cycles; rsp_valid after, rsp_rdata=0.
- Misaligned word load, addr 0x6 -> read/write never asserted; rsp_valid next cycle with rsp_error=1. req_size=3 -> same response.
- TIMEOUT=4, waitrequest stuck at 1 -> read deasserts after 4 stalled edges; rsp_error=1 pulse; next request accepted normally.
- reset driven low mid-BUS with waitrequest=1 -> read/write/byteenable=0 immediately (async); no rsp_valid; after release, req_ready=1.

Source files
------------

// File: rtl/avalon_lsu_port.sv
// Avalon-MM master port for the core's load/store unit.
// It serves one fetch, load or store at a time and returns aligned, extended read data.
module avalon_lsu_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [31:0]           writedata,
    output logic [3:0]            byteenable,
    input  logic [31:0]           readdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] address_next;
    logic                  read_next, write_next, rsp_error_next;
    logic [31:0]           writedata_next, rsp_rdata_next;
    logic [3:0]            byteenable_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [1:0]            lat_size, lat_size_next, lat_lo, lat_lo_next;
    logic                  lat_signed, lat_signed_next;
    logic                  bad_req;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'd0:    lane_mask = 4'b0001 << lo;
            2'd1:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd0:    replicate = {4{d[7:0]}};
            2'd1:    replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*lo +: 8];
        h = d[16*lo[1] +: 16];
        case (size)
            2'd0:    extract = {{24{sgn & b[7]}}, b};
            2'd1:    extract = {{16{sgn & h[15]}}, h};
            default: extract = d;
        endcase
    endfunction

    assign bad_req   = (req_size == 2'd3) ||
                       (req_size == 2'd1 && req_addr[0]) ||
                       (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next      = state;
        address_next    = address;
        read_next       = read;
        write_next      = write;
        writedata_next  = writedata;
        byteenable_next = byteenable;
        rsp_rdata_next  = rsp_rdata;
        rsp_error_next  = rsp_error;
        cnt_next        = cnt;
        lat_size_next   = lat_size;
        lat_lo_next     = lat_lo;
        lat_signed_next = lat_signed;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_size_next   = req_size;
                    lat_lo_next     = req_addr[1:0];
                    lat_signed_next = req_signed;
                    rsp_rdata_next  = '0;
                    if (bad_req) begin
                        state_next     = RESP;
                        rsp_error_next = 1'b1;
                    end else begin
                        state_next      = BUS;
                        address_next    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        read_next       = !req_write;
                        write_next      = req_write;
                        byteenable_next = lane_mask(req_size, req_addr[1:0]);
                        writedata_next  = replicate(req_size, req_wdata);
                        cnt_next        = '0;
                    end
                end
            end
            BUS: begin
                // Bus outputs stay registered unchanged while the slave stalls.
                if (!waitrequest || (TIMEOUT != 0 && cnt == CNT_LAST)) begin
                    state_next      = RESP;
                    rsp_error_next  = waitrequest;
                    rsp_rdata_next  = (waitrequest || write) ? 32'd0
                                      : extract(readdata, lat_size, lat_signed, lat_lo);
                    address_next    = '0;
                    read_next       = 1'b0;
                    write_next      = 1'b0;
                    writedata_next  = '0;
                    byteenable_next = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RESP: begin
                state_next     = IDLE;
                rsp_rdata_next = '0;
                rsp_error_next = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            cnt        <= '0;
            lat_size   <= '0;
            lat_lo     <= '0;
            lat_signed <= 1'b0;
        end else begin
            state      <= state_next;
            address    <= address_next;
            read       <= read_next;
            write      <= write_next;
            writedata  <= writedata_next;
            byteenable <= byteenable_next;
            rsp_rdata  <= rsp_rdata_next;
            rsp_error  <= rsp_error_next;
            cnt        <= cnt_next;
            lat_size   <= lat_size_next;
            lat_lo     <= lat_lo_next;
            lat_signed <= lat_signed_next;
        end
    end

endmodule

// File: tb/tb_avalon_lsu_port.sv
// Bench for avalon_lsu_port: directed and random transactions checked cycle by cycle
// against a transaction-level model of the port.
module tb_avalon_lsu_port;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write, req_signed;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_error, busy;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] address;
    logic          read, write, waitrequest;
    logic [31:0]   writedata, readdata;
    logic [3:0]    byteenable;

    int n_vec = 0;
    int n_err = 0;

    avalon_lsu_port #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 32'(1) << (a % 4);
        if (sz == 2'd1) return ((a & 2) != 0) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                               input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Called #1 after a rising edge with the port idle; leaves #1 after the edge that retires the response.
    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                       input logic [31:0] wd, input int nwait, input logic [31:0] rd);
        bit timed_out = 0;
        req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        if (model_bad(sz, ad)) begin
            req_valid = 1'b0;
            chk("err_read", 32'(read), 32'd0);
            chk("err_write", 32'(write), 32'd0);
            chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("err_rsp_error", 32'(rsp_error), 32'd1);
            chk("err_rsp_rdata", rsp_rdata, 32'd0);
        end else begin
            for (int i = 0; i <= TO; i++) begin
                req_valid   = 1'($urandom_range(0, 1));
                waitrequest = (i < nwait);
                readdata    = (i < nwait) ? $urandom : rd;
                chk("bus_read", 32'(read), 32'(!wr));
                chk("bus_write", 32'(write), 32'(wr));
                chk("bus_address", address, ad & ~32'd3);
                chk("bus_be", 32'(byteenable), model_be(sz, ad));
                if (wr) chk("bus_wdata", writedata, model_wd(sz, wd));
                chk("bus_req_ready", 32'(req_ready), 32'd0);
                chk("bus_rsp_valid", 32'(rsp_valid), 32'd0);
                @(posedge clk); #1;
                if (i >= nwait) break;
                if (i + 1 == TO) begin
                    timed_out = 1;
                    break;
                end
            end
            waitrequest = 1'b0;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_error", 32'(rsp_error), 32'(timed_out));
            chk("rsp_rdata", rsp_rdata, (timed_out || wr) ? 32'd0 : model_load(sz, sg, ad, rd));
            chk("rsp_read", 32'(read), 32'd0);
            chk("rsp_write", 32'(write), 32'd0);
            chk("rsp_be", 32'(byteenable), 32'd0);
            chk("rsp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; waitrequest = 1'b0; readdata = '0;
        #3;
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_be", 32'(byteenable), 32'd0);
        chk("rst_wdata", writedata, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_error", 32'(rsp_error), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        txn(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 0, 32'h80FF_1234);
        txn(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 0, 32'h80FF_1234);
        txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_ABCD, 3, 32'h0);
        txn(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, 32'h0);
        txn(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 0, 32'h0);
        txn(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 2, 32'h8001_7FFF);
        txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 10, 32'h1234_5678);
        txn(1'b1, 2'd0, 1'b0, 32'h41, 32'h0000_00A5, 0, 32'h0);

        // Reset while the bus is stalled
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h80; req_valid = 1'b1;
        waitrequest = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_rst_read", 32'(read), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_read", 32'(read), 32'd0);
        chk("arst_write", 32'(write), 32'd0);
        chk("arst_be", 32'(byteenable), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("after_rst_req_ready", 32'(req_ready), 32'd1);
        end

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            logic [31:0] ad;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad = ad & ~32'd1;
                if (sz == 2'd2) ad = ad & ~32'd3;
            end
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom,
                int'($urandom_range(0, 5)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
